// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the register file slice: default data/address widths
// (also used by the CPU top) and the dump FSM state encoding.
// No ports; import with "import regfile_pkg::*;".
// ---------------------------------------------------------------------------
package regfile_pkg;

    // Default geometry of the KGP-RISC integer register file
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Dump engine states; kept as plain constants for older tools
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_dump_ctrl
// Debug dump engine: walks every register index once and presents each one
// as a valid/ready beat. Each beat's data is snapshotted when it is loaded,
// so later writes to the array do not disturb a stalled beat.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   dumpStart       request a full dump (honoured only when idle)
//   dumpReady       consumer accepts the current beat
//   rdIdx / rdData  read port into the parent's register array
//   dumpValid       beat valid
//   dumpAddr        index of the current beat
//   dumpData        snapshot of the current beat
//   dumpDone        one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dumpStart,
    input  logic              dumpReady,
    output logic [ADDR_W-1:0] rdIdx,
    input  logic [DATA_W-1:0] rdData,
    output logic              dumpValid,
    output logic [ADDR_W-1:0] dumpAddr,
    output logic [DATA_W-1:0] dumpData,
    output logic              dumpDone
);

    // The last index is all ones, so idx never has to wrap
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;

    // While idle the next beat to load is register 0; while scanning it is
    // the one after the beat currently on the bus
    assign rdIdx     = (state == ST_SCAN) ? idx + ADDR_W'(1) : '0;
    assign dumpValid = (state == ST_SCAN);
    assign dumpAddr  = idx;

    // FSM, beat index, beat snapshot and the done pulse. The snapshot is
    // taken from the array value before the edge, so a write landing on the
    // next index in the accept cycle is not part of that beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            dumpData <= '0;
            dumpDone <= 1'b0;
        end else begin
            dumpDone <= 1'b0;
            if (state == ST_IDLE) begin
                if (dumpStart) begin
                    state    <= ST_SCAN;
                    idx      <= '0;
                    dumpData <= rdData;
                end
            end else if (dumpReady) begin
                if (idx == LAST_IDX) begin
                    state    <= ST_IDLE;
                    idx      <= '0;
                    dumpDone <= 1'b1;
                end else begin
                    idx      <= idx + ADDR_W'(1);
                    dumpData <= rdData;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_sb_dump.sv
// ---------------------------------------------------------------------------
// regfile_sb_dump
// Two-read / one-write register file with write-through bypass, a pending
// scoreboard for pipelined issue, optional hardwired zero register and a
// debug dump port.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   rd_addr1/2 -> rd_data1/2      combinational read ports
//   rd_busy1/2                    pending bit of the addressed register
//   wr_en, wr_addr, wr_data       writeback port (also clears pending)
//   iss_en, iss_addr              marks a destination register pending
//   dump_start/valid/ready        dump handshake
//   dump_addr, dump_data          current dump beat
//   dump_done                     pulse after the last beat is accepted
//   res_out                       contents of register RES_ADDR
// ---------------------------------------------------------------------------
module regfile_sb_dump
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RES_ADDR = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done,
    output logic [DATA_W-1:0] res_out
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] RES_IDX = ADDR_W'(RES_ADDR);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wrHit;
    logic              issHit;
    logic [ADDR_W-1:0] dumpRdIdx;
    logic [DATA_W-1:0] dumpRdData;

    // Writes and issues aimed at a hardwired zero register are dropped here,
    // so register 0 can never hold data or become pending
    assign wrHit  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign issHit = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // Register array
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrHit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard: an issue to the same register as a writeback in the same
    // cycle belongs to a newer producer, so the set has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issHit && (iss_addr == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end else if (wrHit && (wr_addr == ADDR_W'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Read port 1: array value, overridden by same-cycle write data, and
    // finally forced to zero for a hardwired register 0
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_busy1 = pending[rd_addr1];
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_busy1 = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    // Read port 2, same priority as port 1
    always_comb begin
        rd_data2 = regs[rd_addr2];
        rd_busy2 = pending[rd_addr2];
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_busy2 = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

    // Mirror and dump read port see the stored array only, never the bypass
    assign res_out    = regs[RES_IDX];
    assign dumpRdData = regs[dumpRdIdx];

    regfile_dump_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dumpCtrl (
        .clk       (clk),
        .rst       (rst),
        .dumpStart (dump_start),
        .dumpReady (dump_ready),
        .rdIdx     (dumpRdIdx),
        .rdData    (dumpRdData),
        .dumpValid (dump_valid),
        .dumpAddr  (dump_addr),
        .dumpData  (dump_data),
        .dumpDone  (dump_done)
    );

endmodule

// File: tb/tb_regfile_sb_dump.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb_dump
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the register file, scoreboard and dump stream.
// ---------------------------------------------------------------------------
module tb_regfile_sb_dump;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] rd_addr1 = '0;
    logic [ADDR_W-1:0] rd_addr2 = '0;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              iss_en = 1'b0;
    logic [ADDR_W-1:0] iss_addr = '0;
    logic              dump_start = 1'b0;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;
    logic [DATA_W-1:0] res_out;

    regfile_sb_dump #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (1),
        .BYPASS   (1),
        .RES_ADDR (31)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done),
        .res_out    (res_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [DATA_W-1:0] mem [DEPTH];
    bit                pend [DEPTH];
    bit                dumpActive;
    int                dumpIdx;
    logic [DATA_W-1:0] dumpSnap;
    bit                doneExp;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] expData(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return mem[a];
    endfunction

    function automatic logic expBusy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        if (wr_en && wr_addr == a) return 1'b0;
        return pend[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
        dumpActive = 1'b0;
        dumpIdx    = 0;
        dumpSnap   = '0;
        doneExp    = 1'b0;
    endtask

    // Effect of one rising edge, computed from the values before the edge
    task automatic modelEdge();
        if (!rst) begin
            modelReset();
            return;
        end
        doneExp = 1'b0;
        if (!dumpActive) begin
            if (dump_start) begin
                dumpActive = 1'b1;
                dumpIdx    = 0;
                dumpSnap   = mem[0];
            end
        end else if (dump_ready) begin
            if (dumpIdx == DEPTH - 1) begin
                dumpActive = 1'b0;
                doneExp    = 1'b1;
            end else begin
                dumpIdx  = dumpIdx + 1;
                dumpSnap = mem[dumpIdx];
            end
        end
        if (wr_en && wr_addr != 0) begin
            mem[wr_addr]  = wr_data;
            pend[wr_addr] = 1'b0;
        end
        if (iss_en && iss_addr != 0) pend[iss_addr] = 1'b1;
    endtask

    task automatic checkAll();
        checkOutput("rdData1", rd_data1, expData(rd_addr1));
        checkOutput("rdData2", rd_data2, expData(rd_addr2));
        checkOutput("rdBusy1", 32'(rd_busy1), 32'(expBusy(rd_addr1)));
        checkOutput("rdBusy2", 32'(rd_busy2), 32'(expBusy(rd_addr2)));
        checkOutput("resOut", res_out, mem[31]);
        checkOutput("dumpValid", 32'(dump_valid), 32'(dumpActive));
        checkOutput("dumpDone", 32'(dump_done), 32'(doneExp));
        if (dumpActive) begin
            checkOutput("dumpAddr", 32'(dump_addr), 32'(dumpIdx));
            checkOutput("dumpData", dump_data, dumpSnap);
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked shortly after
    task automatic applyStimulus();
        #1 checkAll();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] beatValue(input int k);
        if (k == 5) return 32'd64;
        if (k == 12) return 32'd15;
        if (k == 31) return 32'd7;
        return '0;
    endfunction

    initial begin
        modelReset();

        // 1: reset for 10 cycles, then sweep read port 1
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("rstDumpValid", 32'(dump_valid), 0);
        checkOutput("rstDumpDone", 32'(dump_done), 0);
        checkOutput("rstDumpAddr", 32'(dump_addr), 0);
        checkOutput("rstDumpData", dump_data, 0);
        checkOutput("rstResOut", res_out, 0);
        rst = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr1 = ADDR_W'(a);
            #1;
            checkOutput("sweepData", rd_data1, 0);
            checkOutput("sweepBusy", 32'(rd_busy1), 0);
        end
        @(negedge clk);

        // 2: bypass, zero register, mirrored register
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd64; rd_addr1 = 5'd5;
        #1 checkOutput("bypassSame", rd_data1, 32'd64);
        applyStimulus();
        wr_en = 1'b0;
        #1 checkOutput("bypassAfter", rd_data1, 32'd64);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr1 = 5'd0;
        #1 checkOutput("zeroBypass", rd_data1, 0);
        applyStimulus();
        wr_en = 1'b0;
        #1 checkOutput("zeroAfter", rd_data1, 0);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'd7;
        #1 checkOutput("resBeforeEdge", res_out, 0);
        applyStimulus();
        wr_en = 1'b0;
        #1 checkOutput("resAfterEdge", res_out, 32'd7);

        // 3: scoreboard
        iss_en = 1'b1; iss_addr = 5'd12; rd_addr2 = 5'd12;
        applyStimulus();
        iss_en = 1'b0;
        #1 checkOutput("issBusy", 32'(rd_busy2), 1);
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'd15;
        #1;
        checkOutput("wbBusySame", 32'(rd_busy2), 0);
        checkOutput("wbDataSame", rd_data2, 32'd15);
        applyStimulus();
        wr_en = 1'b0;
        #1 checkOutput("wbBusyAfter", 32'(rd_busy2), 0);
        iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = '0;
        rd_addr1 = 5'd7;
        applyStimulus();
        iss_en = 1'b0; wr_en = 1'b0;
        #1 checkOutput("issWinsBusy", 32'(rd_busy1), 1);
        applyStimulus();

        // 4: full dump with ready held high
        dump_ready = 1'b1; dump_start = 1'b1;
        applyStimulus();
        dump_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            checkOutput("fullValid", 32'(dump_valid), 1);
            checkOutput("fullAddr", 32'(dump_addr), 32'(k));
            checkOutput("fullData", dump_data, beatValue(k));
            checkOutput("fullNoDone", 32'(dump_done), 0);
            applyStimulus();
        end
        #1;
        checkOutput("fullDone", 32'(dump_done), 1);
        checkOutput("fullValidEnd", 32'(dump_valid), 0);
        applyStimulus();
        #1 checkOutput("fullDoneOnce", 32'(dump_done), 0);

        // 5: stall at beat 5 while r5 is rewritten, then a mid-scan start
        dump_start = 1'b1;
        applyStimulus();
        dump_start = 1'b0;
        repeat (5) applyStimulus();
        #1;
        checkOutput("stallAddr", 32'(dump_addr), 5);
        checkOutput("stallData", dump_data, 32'd64);
        dump_ready = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd99;
        applyStimulus();
        wr_en = 1'b0;
        for (int s = 0; s < 2; s++) begin
            #1 checkOutput("stallHeld", dump_data, 32'd64);
            applyStimulus();
        end
        #1 checkOutput("stallHeldLast", dump_data, 32'd64);
        dump_start = 1'b1; dump_ready = 1'b1;
        applyStimulus();
        dump_start = 1'b0;
        #1 checkOutput("noRestartAddr", 32'(dump_addr), 6);
        for (int i = 0; i < 40 && dumpActive; i++) applyStimulus();
        applyStimulus();

        // 6: asynchronous reset in the middle of a dump
        dump_start = 1'b1;
        applyStimulus();
        dump_start = 1'b0;
        repeat (10) applyStimulus();
        #1 checkOutput("preRstAddr", 32'(dump_addr), 10);
        #1 rst = 1'b0;
        #1;
        checkOutput("asyncValid", 32'(dump_valid), 0);
        checkOutput("asyncDone", 32'(dump_done), 0);
        checkOutput("asyncRes", res_out, 0);
        rd_addr1 = 5'd5;
        #1 checkOutput("asyncReg5", rd_data1, 0);
        modelReset();
        repeat (2) applyStimulus();
        rst = 1'b1;
        dump_start = 1'b1;
        applyStimulus();
        dump_start = 1'b0;
        #1;
        checkOutput("restartValid", 32'(dump_valid), 1);
        checkOutput("restartAddr", 32'(dump_addr), 0);

        // Randomized traffic concurrent with dumps and stalls
        for (int n = 0; n < 600; n++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = ADDR_W'($urandom_range(0, 31));
            wr_data    = $urandom;
            iss_en     = 1'($urandom_range(0, 2) == 0);
            iss_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 31));
            rd_addr1   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 31));
            rd_addr2   = ($urandom_range(0, 3) == 0) ? iss_addr : ADDR_W'($urandom_range(0, 31));
            dump_ready = 1'($urandom_range(0, 3) != 0);
            dump_start = 1'($urandom_range(0, 15) == 0);
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb_dump.md
Name: regfile_sb_dump

Overview:
Parametrised successor to the 2-read/1-write KGP-RISC register file.
- Adds write-through bypass, a per-register pending scoreboard for pipelined issue, and an optional hardwired zero register.
- Adds a debug dump engine that streams every register out over a valid/ready handshake.
- Sits between decode/issue (reads, pending marking) and writeback; the dump port feeds the board debug path.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports
RES_ADDR, 31, register index mirrored on res_out

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-low
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data
rd_data2  out  DATA_W  read port 2 data
rd_busy1  out  1  pending bit for rd_addr1
rd_busy2  out  1  pending bit for rd_addr2
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
iss_en  in  1  mark destination pending
iss_addr  in  ADDR_W  issued destination register
dump_start  in  1  start a full dump (ignored unless IDLE)
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_addr  out  ADDR_W  index of current beat
dump_data  out  DATA_W  contents of current beat
dump_done  out  1  one-cycle pulse after the last beat is accepted
res_out  out  DATA_W  contents of RES_ADDR

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers and pending bits clear to 0; FSM goes to IDLE.
  - dump_valid, dump_done, dump_addr and dump_data are 0; res_out is 0.
  - Holds while rst is low. Reset mid-dump aborts the dump with no done pulse.
- Reads: combinational, zero latency.
  - If BYPASS=1, wr_en=1 and wr_addr==rd_addrN, then rd_dataN = wr_data and rd_busyN = 0.
  - Otherwise rd_dataN = reg[rd_addrN] and rd_busyN = pending[rd_addrN].
- Writes: reg[wr_addr] <= wr_data on the clock edge.
- ZERO_REG=1: address 0 reads 0 with busy 0, including under bypass; writes and issues to address 0 are dropped.
- Scoreboard, per clock edge:
  - iss_en sets pending[iss_addr].
  - wr_en clears pending[wr_addr].
  - iss and wr to the same address in one cycle leave the bit set (the new producer wins).
  - Different addresses update independently.
- res_out = reg[RES_ADDR], combinational, no bypass (reflects the value after the edge).
- Dump FSM, states IDLE and SCAN; index counter idx (ADDR_W bits).
  - IDLE:
    - dump_start=1 -> SCAN with idx=0; dump_data loaded with reg[0]; dump_valid=1 from the next cycle.
  - SCAN:
    - dump_valid=1 and dump_addr=idx.
    - dump_data is registered and held stable while dump_ready=0, even if reg[idx] is written meanwhile (per-beat snapshot taken at load).
    - On valid&ready with idx<DEPTH-1: idx++ and dump_data loads reg[idx+1]. A write landing on idx+1 in that same cycle is not captured.
    - On valid&ready with idx==DEPTH-1: go to IDLE, dump_valid=0, dump_done=1 for exactly one cycle.
    - dump_start in SCAN is ignored.
  - Normal read/write/issue traffic is fully concurrent with a dump; the dump never stalls the ports.
  - Minimum dump length: DEPTH beats, with done asserted DEPTH+1 cycles after the start edge.
- Widths: no arithmetic; idx never wraps, because the terminal beat returns the FSM to IDLE.

Decomposition:
- Package regfile_pkg: FSM state encoding (IDLE, SCAN) and default DATA_W/ADDR_W constants shared with the CPU top.
- Sub-module regfile_dump_ctrl: FSM, idx counter, dump_data snapshot register and done pulse.
  - Gets the array read value via an idx-addressed read port.
  - Parent holds the array, the scoreboard and the bypass muxing.

Test Plan:
1. rst low 10 cycles, then high; sweep rd_addr1 0..31 -> rd_data1=0, rd_busy1=0, res_out=0, dump_valid=0.
2. wr_en, wr_addr=5, wr_data=64, rd_addr1=5 in the same cycle -> rd_data1=64 in that cycle and after. Write r0=0xFFFFFFFF -> read r0=0. Write r31=7 -> res_out=7 the next cycle.
3. Scoreboard:
   - iss r12, then rd_addr2=12 -> rd_busy2=1.
   - wr r12=15 -> rd_busy2=0 and rd_data2=15 in the same cycle, busy stays 0 afterwards.
   - iss and wr of r7 in the same cycle -> rd_busy1(7)=1 the next cycle.
4. With r5=64, r12=15, r31=7 and dump_ready held 1, pulse dump_start -> 32 beats with addr 0..31, data matching (beat 5=64, 12=15, 31=7, others 0); dump_done pulses once, 33 cycles after start.
5. During a dump, hold dump_ready=0 for 3 cycles at addr 5 while writing r5=99 -> dump_data stays 64 while stalled. Pulse dump_start mid-scan -> no restart, the sequence continues from 6.
6. Drive rst low asynchronously at dump beat 10 -> dump_valid drops immediately, no dump_done, all registers 0. After release, dump_start -> beats restart at addr 0.
